// File: rtl/karatsuba_pkg.sv
// Shared types and constants for the sequential 32x32 Karatsuba multiplier.
// Holds the FSM state encoding, datapath widths and the partial-product shift table.
package karatsuba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned NUM_PP = 4;
    localparam int unsigned IDX_W  = 2;

    // idx selects {a half, b half}: 0=lo*lo, 1=lo*hi, 2=hi*lo, 3=hi*hi
    function automatic logic [5:0] pp_shift(input logic [IDX_W-1:0] idx);
        logic [5:0] sh;
        case (idx)
            2'd0:    sh = 6'd0;
            2'd1:    sh = 6'd16;
            2'd2:    sh = 6'd16;
            default: sh = 6'd32;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/karatsuba_mult_16.sv
// Combinational 16x16 unsigned multiplier, one level of Karatsuba on 8-bit halves.
// Three 8/9-bit products replace the four a schoolbook split would need.
module karatsuba_mult_16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] out
);

    logic [15:0] z0;
    logic [15:0] z2;
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic [17:0] zm;
    logic [31:0] mid;

    always_comb begin
        z0  = x[7:0] * y[7:0];
        z2  = x[15:8] * y[15:8];
        sx  = {1'b0, x[7:0]} + {1'b0, x[15:8]};
        sy  = {1'b0, y[7:0]} + {1'b0, y[15:8]};
        zm  = sx * sy;
        // cross term xl*yh + xh*yl, always non-negative
        mid = 32'(zm) - 32'(z0) - 32'(z2);
        out = (32'(z2) << 16) + (mid << 8) + 32'(z0);
    end

endmodule

// File: rtl/karatsuba_mult_32_seq.sv
// Sequential 32x32 unsigned multiplier: four 16x16 partial products issued one per
// cycle through a single shared karatsuba_mult_16 and summed into a 64-bit accumulator.
module karatsuba_mult_32_seq
    import karatsuba_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_product,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [HALF_W-1:0]   mul_x;
    logic [HALF_W-1:0]   mul_y;
    logic [2*HALF_W-1:0] pp;
    logic [PROD_W-1:0]   pp_aligned;

    // multiplier fed only from registered operands, never from in_*
    always_comb begin
        mul_x      = idx_q[1] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
        mul_y      = idx_q[0] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];
        pp_aligned = {32'b0, pp} << pp_shift(idx_q);
    end

    karatsuba_mult_16 u_mult16 (
        .x   (mul_x),
        .y   (mul_y),
        .out (pp)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    tag_d   = in_tag;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = (in_a == '0 || in_b == '0) ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d = acc_q + pp_aligned;
                idx_d = idx_q + 2'd1;
                if (idx_q == IDX_W'(NUM_PP - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        out_valid   = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        out_product = acc_q;
        out_tag     = tag_q;
    end

endmodule
